// File: rtl/switch_conditioner.sv
// switch_conditioner
//   Synchronises an asynchronous switch vector into the clock domain and
//   debounces it as one unit. A new value is committed only after it has
//   been seen unchanged on sync2 for DEBOUNCE_CYCLES+1 consecutive edges
//   (the entry edge plus DEBOUNCE_CYCLES counted edges).
//
// Parameters
//   WIDTH            number of switch bits
//   DEBOUNCE_CYCLES  stable cycles required before commit (>= 2)
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-high
//   switches_raw  in   [WIDTH]  asynchronous pin values
//   switches      out  [WIDTH]  debounced, registered value
//   changed       out  one-cycle strobe in the cycle after a commit
//   busy          out  high while a candidate value is settling

// Two-flop synchroniser for one switch bit.
module switch_conditioner_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_sync1, r_sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
    end
  end

  assign o_q = r_sync2;
endmodule

module switch_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches,
  output logic             changed,
  output logic             busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_SETTLING} state_t;

  logic [WIDTH-1:0] w_sync2;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cand, w_cand_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [WIDTH-1:0] r_sw, w_sw_nxt;
  logic             r_chg, w_chg_nxt;

  // one synchroniser per bit
  for (genvar g = 0; g < WIDTH; g++) begin : g_sync
    switch_conditioner_sync u_sync (
      .clock (clock),
      .reset (reset),
      .i_d   (switches_raw[g]),
      .o_q   (w_sync2[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_STABLE;
      r_cand  <= '0;
      r_count <= '0;
      r_sw    <= '0;
      r_chg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_count <= w_count_nxt;
      r_sw    <= w_sw_nxt;
      r_chg   <= w_chg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_count_nxt = r_count;
    w_sw_nxt    = r_sw;
    w_chg_nxt   = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (w_sync2 != r_sw) begin
          w_cand_nxt  = w_sync2;
          w_count_nxt = '0;
          w_state_nxt = ST_SETTLING;
        end
      end
      ST_SETTLING: begin
        if (w_sync2 == r_sw) begin
          // bounced back to the committed value: abandon quietly
          w_count_nxt = '0;
          w_state_nxt = ST_STABLE;
        end else if (w_sync2 != r_cand) begin
          // any bit moved while settling: restart on the new value
          w_cand_nxt  = w_sync2;
          w_count_nxt = '0;
        end else if (r_count == LAST) begin
          w_sw_nxt    = r_cand;
          w_chg_nxt   = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = ST_STABLE;
        end else begin
          // cannot pass LAST: the branch above catches it first
          w_count_nxt = r_count + CW'(1);
        end
      end
      default: w_state_nxt = ST_STABLE;
    endcase
  end

  assign switches = r_sw;
  assign changed  = r_chg;
  assign busy     = (r_state == ST_SETTLING);
endmodule

// File: tb/tb_switch_conditioner.sv
module tb_switch_conditioner;
  localparam int W  = 4;
  localparam int DC = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] raw;
  logic [W-1:0] sw;
  logic         chg;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  bit chk_en  = 0;

  switch_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clock        (clk),
    .reset        (reset),
    .switches_raw (raw),
    .switches     (sw),
    .changed      (chg),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a value is committed once sync2 has shown the same
  // value, different from the output, on DC+1 consecutive edges.
  logic [W-1:0] p1, p2, m_last, m_sw;
  int           m_run, mr_run;
  logic         m_chg, m_busy, mr_commit;

  always_comb begin
    mr_run = 1;
    if (p2 == m_last) mr_run = (m_run > DC) ? m_run : m_run + 1;
    mr_commit = (p2 != m_sw) && (mr_run > DC);
  end

  always @(posedge clk) begin
    if (reset) begin
      p1 <= '0; p2 <= '0; m_last <= '0; m_run <= 0;
      m_sw <= '0; m_chg <= 1'b0; m_busy <= 1'b0;
    end else begin
      p1     <= raw;
      p2     <= p1;
      m_last <= p2;
      m_run  <= mr_run;
      m_chg  <= mr_commit;
      m_busy <= (p2 != m_sw) && !mr_commit;
      if (mr_commit) m_sw <= p2;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_switches", sw, m_sw);
      chk("model_changed", chg, m_chg);
      chk("model_busy", busy, m_busy);
      if (chg === 1'b1) pulses++;
    end
  end

  // advance n negedges, then settle just after the edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] raw;
    int           hold;
    logic [W-1:0] exp_sw;
    int           exp_pulses;
  } vec_t;
  vec_t tbl[$];

  initial begin
    tbl.push_back('{4'b0001,  2, 4'b0000, 0});  // bounce-back
    tbl.push_back('{4'b0000, 10, 4'b0000, 0});
    tbl.push_back('{4'b0011,  2, 4'b0000, 0});  // multi-value bounce
    tbl.push_back('{4'b0111, 10, 4'b0111, 1});
    tbl.push_back('{4'b0000, 10, 4'b0000, 1});
    tbl.push_back('{4'b1010,  3, 4'b0000, 0});  // short glitch
    tbl.push_back('{4'b0000, 10, 4'b0000, 0});
    tbl.push_back('{4'b1010,  4, 4'b0000, 0});  // DC-long glitch rejected
    tbl.push_back('{4'b0000, 10, 4'b0000, 0});
    tbl.push_back('{4'b1010,  5, 4'b0000, 0});  // DC+1 commits late
    tbl.push_back('{4'b0000, 12, 4'b0000, 2});

    reset = 1'b1;
    raw   = '0;
    #7 reset = 1'b0;
    chk_en = 1;
    step(1);

    // 1: reset with all switches on, then debounce from zero
    raw = 4'b1111; reset = 1'b1;
    step(1);
    chk("rst1_sw", sw, 0); chk("rst1_chg", chg, 0); chk("rst1_busy", busy, 0);
    step(1);
    chk("rst2_sw", sw, 0); chk("rst2_chg", chg, 0); chk("rst2_busy", busy, 0);
    reset = 1'b0;
    step(6);
    chk("t1_pre_sw", sw, 0);
    step(1);
    chk("t1_sw", sw, 4'b1111); chk("t1_chg", chg, 1);
    step(1);
    chk("t1_chg_fall", chg, 0);
    raw = '0;
    step(12);
    chk("t1_back_sw", sw, 0);

    // 2: clean change latency
    raw = 4'b0101;
    step(1); chk("t2_busy_e0", busy, 0);
    step(1); chk("t2_busy_e1", busy, 0);
    step(1); chk("t2_busy_e2", busy, 1);
    step(3); chk("t2_sw_e5", sw, 0); chk("t2_busy_e5", busy, 1);
    step(1); chk("t2_sw_e6", sw, 4'b0101); chk("t2_chg_e6", chg, 1); chk("t2_busy_e6", busy, 0);
    step(1); chk("t2_chg_e7", chg, 0);
    raw = '0;
    step(12);

    // 3/4 and glitch boundaries: table
    foreach (tbl[i]) begin
      raw = tbl[i].raw;
      pulses = 0;
      step(tbl[i].hold);
      chk($sformatf("tbl%0d_sw", i), sw, tbl[i].exp_sw);
      chk($sformatf("tbl%0d_pulses", i), pulses, tbl[i].exp_pulses);
    end

    // 5: reset three cycles into settling
    raw = 4'b1000;
    step(5);
    chk("t5_busy", busy, 1);
    reset = 1'b1; pulses = 0;
    step(1);
    chk("t5_rst_sw", sw, 0); chk("t5_rst_chg", chg, 0); chk("t5_rst_busy", busy, 0);
    step(1);
    reset = 1'b0;
    step(6);
    chk("t5_pre_sw", sw, 0); chk("t5_pulses", pulses, 0);
    step(1);
    chk("t5_sw", sw, 4'b1000); chk("t5_chg", chg, 1);
    raw = '0;
    step(12);

    // 6: sweep, 6 cycles per value
    pulses = 0;
    for (int v = 1; v < 16; v++) begin
      raw = W'(v);
      step(1);
      chk($sformatf("sweep%0d_sw", v - 1), sw, v - 1);
      step(5);
    end
    step(1);
    chk("sweep_final_sw", sw, 4'b1111);
    chk("sweep_pulses", pulses, 15);

    // random segments against the model, with occasional resets
    for (int s = 0; s < 150; s++) begin
      raw = W'($urandom_range(0, 15));
      reset = ($urandom_range(0, 19) == 0);
      step(1);
      reset = 1'b0;
      step($urandom_range(0, 9));
    end
    step(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Input-conditioning stage directly upstream of the SCIC core's `switches` port. It synchronises the asynchronous board switch vector into the `clock` domain, debounces it as a whole vector, and presents a glitch-free `switches` bus plus a one-cycle `changed` strobe. Instantiated at top level between the board pins and `SCIC`. Its output is a plain registered level that the core samples whenever it executes an input read.

## Interface
- `WIDTH`, default 4: number of switch bits.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a new value is committed.
  - Legal range is ≥ 2.
  - Set to 1_000_000 for a 10 ms debounce at 100 MHz on hardware.
- `clock`: input, 1 bit. Single clock, rising-edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `switches_raw`: input, WIDTH bits. Asynchronous pin values.
- `switches`: output, WIDTH bits. Debounced, registered value; feeds the SCIC `switches` port.
- `changed`: output, 1 bit. High for exactly one cycle in the cycle after `switches` updates.
- `busy`: output, 1 bit. High while a candidate value is settling.

## Operation
- **Synchroniser:** two flops per bit, `sync1` then `sync2`. Only `sync2` is used downstream.
- **Registers:**
  - `candidate`: WIDTH bits.
  - `count`: $clog2(DEBOUNCE_CYCLES) bits, unsigned, never wraps.
  - `state`: STABLE or SETTLING.
- **STABLE**, `busy`=0:
  - If `sync2` != `switches`: load `candidate`=`sync2`, set `count`=0, go to SETTLING.
  - Otherwise hold.
- **SETTLING**, `busy`=1. Checks are in priority order:
  1. `sync2` == `switches` (bounce back to the old value): go to STABLE, set `count`=0, `switches` unchanged, no `changed` pulse.
  2. `sync2` != `candidate` (new bounce to a different value): reload `candidate`=`sync2`, set `count`=0, stay in SETTLING.
  3. `count` == DEBOUNCE_CYCLES-1: set `switches`=`candidate`, `changed`=1, `count`=0, go to STABLE.
  4. Otherwise: `count` = `count`+1.
- **Vector handling:** the whole vector is debounced as one unit. Any bit toggling during settling restarts the count.
- **`changed`:** is 0 in every cycle except the single cycle following a commit.
- **Reset:**
  - When `reset` is sampled high at a rising edge, the following clear on that edge: `sync1`, `sync2`, `candidate`, `count`, `switches`, `changed`.
  - `state` returns to STABLE.
  - A settling sequence in progress is aborted with no pulse.
  - If `switches_raw` is nonzero at reset release, it is debounced again from `switches`=0.

## Timing
- **Reset values:** `switches`=0, `changed`=0, `busy`=0.
- **Commit latency:**
  - Take a raw change that is stable from before edge E through the commit.
  - `sync2` reflects it after edge E+1.
  - SETTLING is entered at edge E+2.
  - `switches` and `changed` update at edge E+2+DEBOUNCE_CYCLES.
  - Total latency from the capturing edge E: DEBOUNCE_CYCLES+2 edges.
- **`busy`:** is high from edge E+2 until the commit edge.
- **Pulse width:** `changed` falls on the next edge; it is never wider than one cycle.
- **Back-to-back changes:** a second raw change arriving in the commit cycle is seen by STABLE on the next edge. No change is lost, provided each value is stable for at least DEBOUNCE_CYCLES+2 cycles.
- **Glitch rejection:** any `sync2` pulse shorter than DEBOUNCE_CYCLES cycles never reaches `switches`.
- **`count` bound:** `count` saturates at DEBOUNCE_CYCLES-1 by construction. No overflow path exists.

## Test plan
Bench conditions: DEBOUNCE_CYCLES=4, 100 MHz clock, `reset` released at 7 ns.

1. **Reset:** hold `reset` high for 2 edges with `switches_raw`=4'b1111 → `switches`=0, `changed`=0, `busy`=0 during reset. After release, `switches`=4'b1111 exactly 6 edges after the first post-reset edge, with a single `changed` pulse.
2. **Clean change:** `switches_raw` 0→4'b0101, stable → `busy` rises 2 edges after capture, `switches`=4'b0101 at capture+6 edges, `changed` high for exactly 1 cycle.
3. **Bounce-back:** toggle bit 0 to 1 for 2 cycles, then return to 0 → `busy` pulses high, `switches` stays 0, `changed` never asserts.
4. **Multi-value bounce:** 0→4'b0011 for 2 cycles, then 4'b0111 stable → `switches` goes directly to 4'b0111, never 4'b0011. Commit occurs 6 edges after the 4'b0111 capture.
5. **Reset mid-settling:** assert `reset` 3 cycles into SETTLING for a 4'b1000 change → no pulse, all outputs 0. After release with the input still 4'b1000, it commits 6 edges later.
6. **Sequential sweep:** step `switches_raw` 0001→0010→…→1111, each held 60 ns → `switches` follows every value in order. 15 `changed` pulses total, each 1 cycle wide.
